// File: rtl/Opcodes_pkg.sv
// Opcodes_pkg
// Shared types for the instruction sequencer:
//   instruction_t     - decoded instruction flags consumed by the sequencer
//   sequencer_state_t - the six sequencer states, exported on the 'state' port
package Opcodes_pkg;

    // Only the decoded properties the sequencer needs to steer its states.
    typedef struct packed {
        logic is_load;   // instruction reads data memory
        logic is_store;  // instruction writes data memory
        logic has_rd;    // instruction writes a destination register
        logic is_mret;   // return from interrupt handler
    } instruction_t;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        LOAD      = 3'd3,
        STORE     = 3'd4,
        WRITEBACK = 3'd5
    } sequencer_state_t;

endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle control sequencer: walks each instruction through
// FETCH -> DECODE -> EXECUTE -> [LOAD | STORE] -> WRITEBACK, issues the
// memory handshake, per-stage capture strobes, interrupt entry and the
// retired-instruction counter.
// Ports:
//   clk, reset            - clock; synchronous active-high reset
//   instr                 - decoded instruction, held from DECODE to WRITEBACK
//   mem_ready             - memory accepts/completes the pending access
//   irq                   - level-sensitive interrupt request
//   mem_valid             - memory access request
//   mem_is_fetch          - 1 = instruction fetch, 0 = data access
//   state                 - current sequencer state
//   fetch_en .. pc_en     - single-cycle stage capture strobes
//   irq_accept, in_irq    - interrupt taken pulse, interrupt-mode flag
//   instret               - retired instruction count (wraps)
module instr_sequencer
    import Opcodes_pkg::*;
#(
    parameter bit IRQ_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  instruction_t     instr,
    input  logic             mem_ready,
    input  logic             irq,
    output logic             mem_valid,
    output logic             mem_is_fetch,
    output sequencer_state_t state,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             load_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic             irq_accept,
    output logic             in_irq,
    output logic [31:0]      instret
);

    sequencer_state_t state_q, state_d;
    logic             in_irq_q, in_irq_d;
    logic [31:0]      instret_q, instret_d;
    logic             irq_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            in_irq_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            in_irq_q  <= in_irq_d;
            instret_q <= instret_d;
        end
    end

    // An mret in WRITEBACK blocks acceptance so the handler exit completes
    // before a still-pending request re-enters at the next instruction.
    assign irq_take = IRQ_ENABLE && irq && !in_irq_q && !instr.is_mret;

    always_comb begin
        state_d      = state_q;
        in_irq_d     = in_irq_q;
        instret_d    = instret_q;
        mem_valid    = 1'b0;
        mem_is_fetch = 1'b0;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        load_en      = 1'b0;
        writeback_en = 1'b0;
        pc_en        = 1'b0;
        irq_accept   = 1'b0;

        case (state_q)
            FETCH: begin
                mem_valid    = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ready) begin
                    fetch_en = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                decode_en = 1'b1;
                state_d   = EXECUTE;
            end
            EXECUTE: begin
                execute_en = 1'b1;
                if (instr.is_load)       state_d = LOAD;
                else if (instr.is_store) state_d = STORE;
                else                     state_d = WRITEBACK;
            end
            LOAD: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    load_en = 1'b1;
                    state_d = WRITEBACK;
                end
            end
            STORE: begin
                mem_valid = 1'b1;
                if (mem_ready) state_d = WRITEBACK;
            end
            WRITEBACK: begin
                pc_en        = 1'b1;
                writeback_en = instr.has_rd;
                instret_d    = instret_q + 32'd1;
                irq_accept   = irq_take;
                if (irq_take)           in_irq_d = 1'b1;
                else if (instr.is_mret) in_irq_d = 1'b0;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset abandons any in-flight access and silences every strobe.
        if (reset) begin
            mem_valid    = 1'b0;
            fetch_en     = 1'b0;
            decode_en    = 1'b0;
            execute_en   = 1'b0;
            load_en      = 1'b0;
            writeback_en = 1'b0;
            pc_en        = 1'b0;
            irq_accept   = 1'b0;
        end
    end

    assign state   = state_q;
    assign in_irq  = in_irq_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    import Opcodes_pkg::*;

    logic             clk = 1'b0;
    logic             reset, mem_ready, irq;
    instruction_t     instr;

    logic             mem_valid, mem_is_fetch, fetch_en, decode_en, execute_en;
    logic             load_en, writeback_en, pc_en, irq_accept, in_irq;
    sequencer_state_t state;
    logic [31:0]      instret;

    logic             mem_valid_n, mem_is_fetch_n, fetch_en_n, decode_en_n, execute_en_n;
    logic             load_en_n, writeback_en_n, pc_en_n, irq_accept_n, in_irq_n;
    sequencer_state_t state_n;
    logic [31:0]      instret_n;

    always #5 clk = ~clk;

    instr_sequencer #(.IRQ_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .irq(irq),
        .mem_valid(mem_valid), .mem_is_fetch(mem_is_fetch), .state(state),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .load_en(load_en), .writeback_en(writeback_en), .pc_en(pc_en),
        .irq_accept(irq_accept), .in_irq(in_irq), .instret(instret)
    );

    instr_sequencer #(.IRQ_ENABLE(1'b0)) dut_noirq (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .irq(irq),
        .mem_valid(mem_valid_n), .mem_is_fetch(mem_is_fetch_n), .state(state_n),
        .fetch_en(fetch_en_n), .decode_en(decode_en_n), .execute_en(execute_en_n),
        .load_en(load_en_n), .writeback_en(writeback_en_n), .pc_en(pc_en_n),
        .irq_accept(irq_accept_n), .in_irq(in_irq_n), .instret(instret_n)
    );

    localparam instruction_t ADDI = 4'b0010;
    localparam instruction_t LW   = 4'b1010;
    localparam instruction_t SW   = 4'b0100;
    localparam instruction_t MRET = 4'b0001;
    localparam instruction_t NOP  = 4'b0000;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // {mem_valid, mem_is_fetch, fetch_en, decode_en, execute_en, load_en,
    //  writeback_en, pc_en, irq_accept, in_irq}
    function automatic logic [9:0] strb_main();
        return {mem_valid, mem_is_fetch, fetch_en, decode_en, execute_en,
                load_en, writeback_en, pc_en, irq_accept, in_irq};
    endfunction

    function automatic logic [9:0] strb_noirq();
        return {mem_valid_n, mem_is_fetch_n, fetch_en_n, decode_en_n, execute_en_n,
                load_en_n, writeback_en_n, pc_en_n, irq_accept_n, in_irq_n};
    endfunction

    typedef struct {
        instruction_t     ins;
        bit               rdy;
        bit               irq;
        bit               rst;
        sequencer_state_t st;
        logic [9:0]       strb;
        logic [31:0]      iret;
    } vec_t;

    vec_t tq[$];

    task automatic add(input instruction_t ins, input bit rdy, input bit irq_i, input bit rst,
                       input sequencer_state_t st, input logic [9:0] strb, input logic [31:0] iret);
        vec_t v;
        v.ins = ins; v.rdy = rdy; v.irq = irq_i; v.rst = rst;
        v.st = st; v.strb = strb; v.iret = iret;
        tq.push_back(v);
    endtask

    // Reference model state: position along the current instruction's route.
    int               idx;
    bit               m_irq;
    logic [31:0]      m_ret;
    sequencer_state_t rt[$];
    sequencer_state_t est;
    logic [9:0]       exp_s;
    bit               acc, waits;

    function automatic instruction_t pick();
        case ($urandom_range(0, 4))
            0:       return ADDI;
            1:       return LW;
            2:       return SW;
            3:       return MRET;
            default: return NOP;
        endcase
    endfunction

    initial begin
        reset = 1'b1; mem_ready = 1'b1; irq = 1'b0; instr = ADDI;

        // 0: reset held
        add(ADDI, 1, 0, 1, FETCH,     10'b0100000000, 0);
        // addi x1
        add(ADDI, 1, 0, 0, FETCH,     10'b1110000000, 0);
        add(ADDI, 1, 0, 0, DECODE,    10'b0001000000, 0);
        add(ADDI, 1, 0, 0, EXECUTE,   10'b0000100000, 0);
        add(ADDI, 1, 0, 0, WRITEBACK, 10'b0000001100, 0);
        // sw
        add(SW,   1, 0, 0, FETCH,     10'b1110000000, 1);
        add(SW,   1, 0, 0, DECODE,    10'b0001000000, 1);
        add(SW,   1, 0, 0, EXECUTE,   10'b0000100000, 1);
        add(SW,   1, 0, 0, STORE,     10'b1000000000, 1);
        add(SW,   1, 0, 0, WRITEBACK, 10'b0000000100, 1);
        // addi with irq: accepted
        add(ADDI, 1, 1, 0, FETCH,     10'b1110000000, 2);
        add(ADDI, 1, 1, 0, DECODE,    10'b0001000000, 2);
        add(ADDI, 1, 1, 0, EXECUTE,   10'b0000100000, 2);
        add(ADDI, 1, 1, 0, WRITEBACK, 10'b0000001110, 2);
        // addi with irq while in handler: ignored
        add(ADDI, 1, 1, 0, FETCH,     10'b1110000001, 3);
        add(ADDI, 1, 1, 0, DECODE,    10'b0001000001, 3);
        add(ADDI, 1, 1, 0, EXECUTE,   10'b0000100001, 3);
        add(ADDI, 1, 1, 0, WRITEBACK, 10'b0000001101, 3);
        // mret with irq: leaves handler, no accept
        add(MRET, 1, 1, 0, FETCH,     10'b1110000001, 4);
        add(MRET, 1, 1, 0, DECODE,    10'b0001000001, 4);
        add(MRET, 1, 1, 0, EXECUTE,   10'b0000100001, 4);
        add(MRET, 1, 1, 0, WRITEBACK, 10'b0000000101, 4);
        // next addi, irq still high: accepted now
        add(ADDI, 1, 1, 0, FETCH,     10'b1110000000, 5);
        add(ADDI, 1, 1, 0, DECODE,    10'b0001000000, 5);
        add(ADDI, 1, 1, 0, EXECUTE,   10'b0000100000, 5);
        add(ADDI, 1, 1, 0, WRITEBACK, 10'b0000001110, 5);
        // mret to leave
        add(MRET, 1, 0, 0, FETCH,     10'b1110000001, 6);
        add(MRET, 1, 0, 0, DECODE,    10'b0001000001, 6);
        add(MRET, 1, 0, 0, EXECUTE,   10'b0000100001, 6);
        add(MRET, 1, 0, 0, WRITEBACK, 10'b0000000101, 6);
        add(ADDI, 1, 0, 0, FETCH,     10'b1110000000, 7);
        add(ADDI, 1, 0, 0, DECODE,    10'b0001000000, 7);
        add(ADDI, 1, 0, 0, EXECUTE,   10'b0000100000, 7);
        add(ADDI, 1, 0, 0, WRITEBACK, 10'b0000001100, 7);
        // lw with three wait cycles: 8 cycles total
        add(LW,   1, 0, 0, FETCH,     10'b1110000000, 8);
        add(LW,   1, 0, 0, DECODE,    10'b0001000000, 8);
        add(LW,   1, 0, 0, EXECUTE,   10'b0000100000, 8);
        add(LW,   0, 0, 0, LOAD,      10'b1000000000, 8);
        add(LW,   0, 0, 0, LOAD,      10'b1000000000, 8);
        add(LW,   0, 0, 0, LOAD,      10'b1000000000, 8);
        add(LW,   1, 0, 0, LOAD,      10'b1000010000, 8);
        add(LW,   1, 0, 0, WRITEBACK, 10'b0000001100, 8);
        // fetch wait, then reset during a load wait
        add(LW,   0, 0, 0, FETCH,     10'b1100000000, 9);
        add(LW,   1, 0, 0, FETCH,     10'b1110000000, 9);
        add(LW,   1, 0, 0, DECODE,    10'b0001000000, 9);
        add(LW,   1, 0, 0, EXECUTE,   10'b0000100000, 9);
        add(LW,   0, 0, 0, LOAD,      10'b1000000000, 9);
        add(LW,   0, 0, 1, LOAD,      10'b0000000000, 9);
        add(LW,   0, 0, 0, FETCH,     10'b1100000000, 0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (tq[i]) begin
            instr = tq[i].ins; mem_ready = tq[i].rdy; irq = tq[i].irq; reset = tq[i].rst;
            #1;
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tq[i].st));
            chk($sformatf("tbl%0d_strb", i), 32'(strb_main()), 32'(tq[i].strb));
            chk($sformatf("tbl%0d_instret", i), instret, tq[i].iret);
            @(negedge clk);
        end

        // instret wrap: preload the counter, then retire one addi
        instr = ADDI; mem_ready = 1'b0; irq = 1'b0; reset = 1'b0;
        #1;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        chk("wrap_preload", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clk);
        #1;
        chk("wrap_wb_state", 32'(state), 32'(WRITEBACK));
        chk("wrap_wb_instret", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("wrap_after", instret, 32'h0);
        chk("wrap_state", 32'(state), 32'(FETCH));
        @(negedge clk);

        // Randomized run against the route-based reference model.
        idx = 0; m_irq = 1'b0; m_ret = '0;
        for (int c = 0; c < 3000; c++) begin
            reset = (c < 2) || ($urandom_range(0, 79) == 0);
            if (idx == 0) instr = pick();
            mem_ready = ($urandom_range(0, 99) < 60);
            irq = ($urandom_range(0, 3) == 0);

            rt = '{FETCH, DECODE, EXECUTE};
            if (instr.is_load)       rt.push_back(LOAD);
            else if (instr.is_store) rt.push_back(STORE);
            rt.push_back(WRITEBACK);
            est   = rt[idx];
            waits = (est == FETCH) || (est == LOAD) || (est == STORE);
            acc   = !reset && (est == WRITEBACK) && irq && !m_irq && !instr.is_mret;

            exp_s = '0;
            exp_s[9] = !reset && waits;
            exp_s[8] = (est == FETCH);
            exp_s[7] = !reset && (est == FETCH) && mem_ready;
            exp_s[6] = !reset && (est == DECODE);
            exp_s[5] = !reset && (est == EXECUTE);
            exp_s[4] = !reset && (est == LOAD) && mem_ready;
            exp_s[3] = !reset && (est == WRITEBACK) && instr.has_rd;
            exp_s[2] = !reset && (est == WRITEBACK);
            exp_s[1] = acc;
            exp_s[0] = m_irq;

            #1;
            if (c > 0) begin
                chk("rnd_state", 32'(state), 32'(est));
                chk("rnd_strb", 32'(strb_main()), 32'(exp_s));
                chk("rnd_instret", instret, m_ret);
                chk("rnd_noirq_state", 32'(state_n), 32'(est));
                chk("rnd_noirq_strb", 32'(strb_noirq()), 32'(exp_s & 10'b1111111100));
            end

            if (reset) begin
                idx = 0; m_irq = 1'b0; m_ret = '0;
            end else begin
                if (est == WRITEBACK) begin
                    m_ret = m_ret + 32'd1;
                    if (acc)                m_irq = 1'b1;
                    else if (instr.is_mret) m_irq = 1'b0;
                end
                if (!waits || mem_ready) idx++;
                if (idx == rt.size()) idx = 0;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter IRQ_ENABLE, default 1; when 0, irq is ignored.
REQ-002 The block SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port instr  input  instruction_t  decoded instruction; stable from DECODE through WRITEBACK.
REQ-005 The block SHALL have port mem_ready  input  1  memory accepts/completes the current access.
REQ-006 The block SHALL have port irq  input  1  level-sensitive interrupt request.
REQ-007 The block SHALL have port mem_valid  output  1  memory access request.
REQ-008 The block SHALL have port mem_is_fetch  output  1  1 = instruction fetch, 0 = data access.
REQ-009 The block SHALL have port state  output  sequencer_state_t  current state.
REQ-010 The block SHALL have ports fetch_en, decode_en, execute_en, load_en, writeback_en, pc_en  output  1 each  per-stage capture strobes.
REQ-011 The block SHALL have ports irq_accept and in_irq  output  1 each  interrupt taken pulse and interrupt-mode flag.
REQ-012 The block SHALL have port instret  output  32  count of retired instructions.

Function
REQ-013 States SHALL be FETCH, DECODE, EXECUTE, LOAD, STORE, WRITEBACK; exactly one is active per cycle.
REQ-014 FETCH: mem_valid=1, mem_is_fetch=1; on mem_ready -> DECODE, fetch_en=1 that cycle; otherwise stay, request held unchanged.
REQ-015 DECODE: decode_en=1; next state is always EXECUTE (1 cycle).
REQ-016 EXECUTE: execute_en=1; next state LOAD if instr.is_load, else STORE if instr.is_store, else WRITEBACK.
REQ-017 LOAD: mem_valid=1, mem_is_fetch=0; on mem_ready -> WRITEBACK, load_en=1 that cycle.
REQ-018 STORE: mem_valid=1, mem_is_fetch=0; on mem_ready -> WRITEBACK.
REQ-019 mem_valid SHALL never deassert in FETCH/LOAD/STORE before mem_ready is sampled high.
REQ-020 WRITEBACK: pc_en=1; writeback_en=instr.has_rd; next state always FETCH.
REQ-021 instret SHALL increment by 1 in every WRITEBACK cycle, wrapping 0xFFFFFFFF -> 0.
REQ-022 irq_accept SHALL pulse in WRITEBACK iff IRQ_ENABLE & irq & !in_irq & !instr.is_mret.
REQ-023 in_irq SHALL set on the cycle after irq_accept and clear after a WRITEBACK with instr.is_mret.
REQ-024 irq asserted together with an mret in WRITEBACK SHALL NOT be accepted that cycle; it is accepted at the next instruction's WRITEBACK if still high.
REQ-025 irq outside WRITEBACK SHALL have no effect; no instruction is aborted.
REQ-026 Minimum latency SHALL be 4 cycles per non-memory instruction, 5 per load/store, with zero-wait memory.
REQ-027 All strobes SHALL be combinational from state and inputs; no strobe lasts more than one cycle per instruction.

Reset
REQ-028 On a clk edge with reset=1, state SHALL become FETCH, in_irq 0, instret 0.
REQ-029 While reset=1, mem_valid and all *_en and irq_accept outputs SHALL be forced 0.
REQ-030 Reset asserted mid-access SHALL abandon the access; the first cycle after reset deasserts SHALL begin a fresh FETCH.

Structure
REQ-031 sequencer_state_t SHALL be an enum in Opcodes_pkg, alongside instruction_t.
REQ-032 The block SHALL be a single module with no sub-modules; instret is an inline counter.

Verification
REQ-033 addi x1 (has_rd=1), mem_ready always 1 -> states FETCH,DECODE,EXECUTE,WRITEBACK; writeback_en=1 once; instret 0->1.
REQ-034 lw x2 with mem_ready low for 3 LOAD cycles -> mem_valid held 3 cycles, mem_is_fetch=0, load_en on 4th, total 8 cycles.
REQ-035 sw (has_rd=0) -> STORE visited, writeback_en=0, pc_en=1, instret increments.
REQ-036 irq=1 during addi -> irq_accept at WRITEBACK, in_irq=1; second irq ignored; mret retires -> in_irq=0.
REQ-037 irq=1 coincident with mret WRITEBACK -> no irq_accept; accepted at next instruction's WRITEBACK.
REQ-038 Force instret=0xFFFFFFFF then retire -> 0; reset during LOAD wait -> mem_valid=0 immediately, FETCH after release.
